// File: rtl/multicycle_control.sv
// Multicycle RV32I sequencing controller.
// Steps FETCH/DECODE/EXECUTE/MEM/WB and drives datapath strobes.
module multicycle_control #(
  parameter int MEM_LATENCY = 1,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 RUN,
  input  logic [6:0]           OPCODE,
  output logic                 PC_WRITE,
  output logic                 PC_WRITE_COND,
  output logic                 PC_SRC,
  output logic                 IR_WRITE,
  output logic                 MEM_WRITE,
  output logic                 REG_WRITE,
  output logic [1:0]           ALU_SRC_A,
  output logic [1:0]           ALU_SRC_B,
  output logic [1:0]           ALU_OP,
  output logic [1:0]           MEM_TO_REG,
  output logic [2:0]           STATE,
  output logic                 INSTR_DONE,
  output logic                 ILLEGAL,
  output logic [CNT_WIDTH-1:0] INSTR_COUNT
);

  localparam int WW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [WW-1:0] WAIT_INIT = WW'(MEM_LATENCY - 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    C_NONE, C_R, C_I, C_LOAD, C_STORE,
    C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC
  } cls_t;

  state_t              state, next;
  cls_t                cls, dec_cls;
  logic [WW-1:0]       wait_cnt;
  logic                go;
  logic                started;
  logic                wait_zero;
  logic                cnt_en;
  logic [CNT_WIDTH-1:0] count;

  // go remembers that RUN was accepted on the first FETCH cycle
  assign started   = go | RUN;
  assign wait_zero = (wait_cnt == '0);
  assign cnt_en    = (state == S_FETCH && started) ||
                     (state == S_MEM && cls == C_LOAD);
  assign STATE       = state;
  assign INSTR_COUNT = count;

  // Opcode to instruction class
  always_comb begin
    dec_cls = C_NONE;
    unique case (1'b1)
      (OPCODE == 7'b0110011): dec_cls = C_R;
      (OPCODE == 7'b0010011): dec_cls = C_I;
      (OPCODE == 7'b0000011): dec_cls = C_LOAD;
      (OPCODE == 7'b0100011): dec_cls = C_STORE;
      (OPCODE == 7'b1100011): dec_cls = C_BRANCH;
      (OPCODE == 7'b1101111): dec_cls = C_JAL;
      (OPCODE == 7'b1100111): dec_cls = C_JALR;
      (OPCODE == 7'b0110111): dec_cls = C_LUI;
      (OPCODE == 7'b0010111): dec_cls = C_AUIPC;
      default:                dec_cls = C_NONE;
    endcase
  end

  // State, wait counter, latched class and retire counter
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state    <= S_FETCH;
      wait_cnt <= WAIT_INIT;
      go       <= 1'b0;
      cls      <= C_NONE;
      count    <= '0;
    end else begin
      state <= next;
      go    <= (state == S_FETCH) && started && !wait_zero;
      if (cnt_en)
        wait_cnt <= wait_zero ? WAIT_INIT : wait_cnt - 1'b1;
      if (state == S_DECODE)
        cls <= dec_cls;
      count <= count + CNT_WIDTH'(INSTR_DONE);
    end
  end

  // Next-state selection
  always_comb begin
    next = state;
    unique case (state)
      S_FETCH:  if (started && wait_zero) next = S_DECODE;
      S_DECODE: next = (dec_cls == C_NONE) ? S_HALT : S_EXEC;
      S_EXEC: begin
        unique case (cls)
          C_LOAD, C_STORE: next = S_MEM;
          C_BRANCH:        next = S_FETCH;
          default:         next = S_WB;
        endcase
      end
      S_MEM: begin
        if (cls == C_STORE)  next = S_FETCH;
        else if (wait_zero)  next = S_WB;
      end
      S_WB:     next = S_FETCH;
      S_HALT:   next = S_HALT;
      default:  next = S_FETCH;
    endcase
  end

  // Datapath strobes and selects; all quiet while reset is held
  always_comb begin
    PC_WRITE      = 1'b0;
    PC_WRITE_COND = 1'b0;
    PC_SRC        = 1'b0;
    IR_WRITE      = 1'b0;
    MEM_WRITE     = 1'b0;
    REG_WRITE     = 1'b0;
    ALU_SRC_A     = 2'd0;
    ALU_SRC_B     = 2'd0;
    ALU_OP        = 2'd0;
    MEM_TO_REG    = 2'd0;
    INSTR_DONE    = 1'b0;
    ILLEGAL       = 1'b0;
    if (RESET_N) begin
      unique case (state)
        S_FETCH: begin
          ALU_SRC_B = 2'd2;
          if (started && wait_zero) begin
            IR_WRITE = 1'b1;
            PC_WRITE = 1'b1;
          end
        end
        S_DECODE: ALU_SRC_B = 2'd1;
        S_EXEC: begin
          unique case (cls)
            C_R: begin
              ALU_SRC_A = 2'd2;
              ALU_OP    = 2'd2;
            end
            C_I: begin
              ALU_SRC_A = 2'd2;
              ALU_SRC_B = 2'd1;
              ALU_OP    = 2'd2;
            end
            C_LOAD, C_STORE: begin
              ALU_SRC_A = 2'd2;
              ALU_SRC_B = 2'd1;
            end
            C_BRANCH: begin
              ALU_SRC_A     = 2'd2;
              ALU_OP        = 2'd1;
              PC_WRITE_COND = 1'b1;
              PC_SRC        = 1'b1;
              INSTR_DONE    = 1'b1;
            end
            C_JAL: begin
              PC_WRITE = 1'b1;
              PC_SRC   = 1'b1;
            end
            C_JALR: begin
              ALU_SRC_A = 2'd2;
              ALU_SRC_B = 2'd1;
              PC_WRITE  = 1'b1;
            end
            C_LUI: begin
              ALU_SRC_A = 2'd1;
              ALU_SRC_B = 2'd1;
            end
            C_AUIPC:  ALU_SRC_B = 2'd1;
            default: ;
          endcase
        end
        S_MEM: begin
          if (cls == C_STORE) begin
            MEM_WRITE  = 1'b1;
            INSTR_DONE = 1'b1;
          end
        end
        S_WB: begin
          REG_WRITE  = 1'b1;
          INSTR_DONE = 1'b1;
          if (cls == C_LOAD)
            MEM_TO_REG = 2'd1;
          else if (cls == C_JAL || cls == C_JALR)
            MEM_TO_REG = 2'd2;
        end
        S_HALT:  ILLEGAL = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-cycle vector tables on a
// latency-1 / 4-bit-counter instance and a latency-2 instance.
module tb_multicycle_control;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_AUI  = 7'b0010111;
  localparam logic [6:0] OP_ILL  = 7'b1111111;

  // stb = {PC_WRITE, PC_WRITE_COND, PC_SRC, IR_WRITE, MEM_WRITE, REG_WRITE}
  typedef struct packed {
    logic [2:0]  st;
    logic [5:0]  stb;
    logic [1:0]  a;
    logic [1:0]  b;
    logic [1:0]  alu;
    logic [1:0]  m2r;
    logic        done;
    logic        ill;
    logic [31:0] cnt;
  } out_t;

  typedef struct {
    logic       rst;
    logic       run;
    logic [6:0] op;
    out_t       exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst1 = 1'b0, run1 = 1'b0;
  logic [6:0] op1 = '0;
  logic       rst2 = 1'b0, run2 = 1'b0;
  logic [6:0] op2 = '0;

  logic       pcw1, pcwc1, pcs1, irw1, mw1, rw1, done1, ill1;
  logic [1:0] a1, b1, alu1, m2r1;
  logic [2:0] st1;
  logic [3:0] cnt1;
  logic       pcw2, pcwc2, pcs2, irw2, mw2, rw2, done2, ill2;
  logic [1:0] a2, b2, alu2, m2r2;
  logic [2:0] st2;
  logic [31:0] cnt2;

  multicycle_control #(.MEM_LATENCY(1), .CNT_WIDTH(4)) u1 (
    .CLK(clk), .RESET_N(rst1), .RUN(run1), .OPCODE(op1),
    .PC_WRITE(pcw1), .PC_WRITE_COND(pcwc1), .PC_SRC(pcs1),
    .IR_WRITE(irw1), .MEM_WRITE(mw1), .REG_WRITE(rw1),
    .ALU_SRC_A(a1), .ALU_SRC_B(b1), .ALU_OP(alu1),
    .MEM_TO_REG(m2r1), .STATE(st1), .INSTR_DONE(done1),
    .ILLEGAL(ill1), .INSTR_COUNT(cnt1)
  );

  multicycle_control #(.MEM_LATENCY(2), .CNT_WIDTH(32)) u2 (
    .CLK(clk), .RESET_N(rst2), .RUN(run2), .OPCODE(op2),
    .PC_WRITE(pcw2), .PC_WRITE_COND(pcwc2), .PC_SRC(pcs2),
    .IR_WRITE(irw2), .MEM_WRITE(mw2), .REG_WRITE(rw2),
    .ALU_SRC_A(a2), .ALU_SRC_B(b2), .ALU_OP(alu2),
    .MEM_TO_REG(m2r2), .STATE(st2), .INSTR_DONE(done2),
    .ILLEGAL(ill2), .INSTR_COUNT(cnt2)
  );

  out_t o1, o2;
  assign o1 = {st1, pcw1, pcwc1, pcs1, irw1, mw1, rw1,
               a1, b1, alu1, m2r1, done1, ill1, 28'd0, cnt1};
  assign o2 = {st2, pcw2, pcwc2, pcs2, irw2, mw2, rw2,
               a2, b2, alu2, m2r2, done2, ill2, cnt2};

  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t vq[$];

  task automatic add(input logic rst, input logic run,
                     input logic [6:0] op, input logic [2:0] st,
                     input logic [5:0] stb, input logic [1:0] a,
                     input logic [1:0] b, input logic [1:0] alu,
                     input logic [1:0] m2r, input logic done,
                     input logic ill, input int cnt);
    vec_t v;
    v.rst = rst;
    v.run = run;
    v.op  = op;
    v.exp = {st, stb, a, b, alu, m2r, done, ill, 32'(cnt)};
    vq.push_back(v);
  endtask

  task automatic fe(input logic [6:0] op, input int c);
    add(1, 1, op, 0, 6'b100100, 0, 2, 0, 0, 0, 0, c);
  endtask
  task automatic de(input logic [6:0] op, input int c);
    add(1, 1, op, 1, 6'b000000, 0, 1, 0, 0, 0, 0, c);
  endtask
  task automatic ex(input logic [6:0] op, input logic [5:0] stb,
                    input logic [1:0] a, input logic [1:0] b,
                    input logic [1:0] alu, input logic done,
                    input int c);
    add(1, 1, op, 2, stb, a, b, alu, 0, done, 0, c);
  endtask
  task automatic wb(input logic [6:0] op, input logic [1:0] m2r,
                    input int c);
    add(1, 1, op, 4, 6'b000001, 0, 0, 0, m2r, 1, 0, c);
  endtask

  task automatic cmp(input string name, input out_t got,
                     input out_t req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got st=%0d stb=%b a=%0d b=%0d alu=%0d m2r=%0d done=%b ill=%b cnt=%0d required st=%0d stb=%b a=%0d b=%0d alu=%0d m2r=%0d done=%b ill=%b cnt=%0d",
               name, got.st, got.stb, got.a, got.b, got.alu, got.m2r,
               got.done, got.ill, got.cnt, req.st, req.stb, req.a,
               req.b, req.alu, req.m2r, req.done, req.ill, req.cnt);
    end
  endtask

  task automatic run_vecs(input int dut);
    foreach (vq[i]) begin
      @(negedge clk);
      if (dut == 1) begin
        rst1 = vq[i].rst; run1 = vq[i].run; op1 = vq[i].op;
      end else begin
        rst2 = vq[i].rst; run2 = vq[i].run; op2 = vq[i].op;
      end
      #1;
      cmp($sformatf("dut%0d_vec%0d", dut, i),
          (dut == 1) ? o1 : o2, vq[i].exp);
    end
    vq.delete();
  endtask

  task automatic step1(input logic run, input logic [6:0] op);
    @(negedge clk);
    rst1 = 1'b1; run1 = run; op1 = op;
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);

    // ---- latency 1, 4-bit counter ----
    add(0, 1, OP_R, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    fe(OP_R, 0); de(OP_R, 0); ex(OP_R, 0, 2, 0, 2, 0, 0); wb(OP_R, 0, 0);
    fe(OP_BR, 1); de(OP_BR, 1); ex(OP_BR, 6'b011000, 2, 0, 1, 1, 1);
    fe(OP_ST, 2); de(OP_ST, 2); ex(OP_ST, 0, 2, 1, 0, 0, 2);
    add(1, 1, OP_ST, 3, 6'b000010, 0, 0, 0, 0, 1, 0, 2);
    fe(OP_JAL, 3); de(OP_JAL, 3); ex(OP_JAL, 6'b101000, 0, 0, 0, 0, 3);
    wb(OP_JAL, 2, 3);
    repeat (5) add(1, 0, OP_I, 0, 0, 0, 2, 0, 0, 0, 0, 4);
    fe(OP_I, 4); de(OP_I, 4); ex(OP_I, 0, 2, 1, 2, 0, 4); wb(OP_I, 0, 4);
    fe(OP_JALR, 5); de(OP_JALR, 5);
    ex(OP_JALR, 6'b100000, 2, 1, 0, 0, 5); wb(OP_JALR, 2, 5);
    fe(OP_LUI, 6); de(OP_LUI, 6); ex(OP_LUI, 0, 1, 1, 0, 0, 6);
    wb(OP_LUI, 0, 6);
    fe(OP_AUI, 7); de(OP_AUI, 7); ex(OP_AUI, 0, 0, 1, 0, 0, 7);
    wb(OP_AUI, 0, 7);
    fe(OP_LD, 8); de(OP_LD, 8); ex(OP_LD, 0, 2, 1, 0, 0, 8);
    add(1, 1, OP_LD, 3, 0, 0, 0, 0, 0, 0, 0, 8); wb(OP_LD, 1, 8);
    fe(OP_R, 9);
    add(1, 0, OP_R, 1, 0, 0, 1, 0, 0, 0, 0, 9);
    add(1, 0, OP_R, 2, 0, 2, 0, 2, 0, 0, 0, 9);
    add(1, 0, OP_R, 4, 6'b000001, 0, 0, 0, 0, 1, 0, 9);
    add(1, 0, OP_R, 0, 0, 0, 2, 0, 0, 0, 0, 10);
    fe(OP_LD, 10); de(OP_LD, 10); ex(OP_LD, 0, 2, 1, 0, 0, 10);
    add(0, 1, OP_LD, 3, 0, 0, 0, 0, 0, 0, 0, 10);
    fe(OP_ILL, 0); de(OP_ILL, 0);
    repeat (10) add(1, 1, OP_ILL, 7, 0, 0, 0, 0, 0, 0, 1, 0);
    add(0, 1, OP_ILL, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, OP_R, 0, 0, 0, 2, 0, 0, 0, 0, 0);
    run_vecs(1);

    // counter wrap: 16 branches on the 4-bit counter
    for (int i = 0; i < 16; i++) begin
      step1(1'b1, OP_BR);
      step1(1'b1, OP_BR);
      step1(1'b1, OP_BR);
      cmp($sformatf("wrap_br%0d", i), o1,
          {3'd2, 6'b011000, 2'd2, 2'd0, 2'd1, 2'd0,
           1'b1, 1'b0, 32'(i)});
    end
    step1(1'b0, OP_BR);
    cmp("wrap_zero", o1,
        {3'd0, 6'b0, 2'd0, 2'd2, 2'd0, 2'd0, 1'b0, 1'b0, 32'd0});

    // ---- latency 2, 32-bit counter ----
    add(0, 1, OP_LD, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, OP_LD, 0, 0, 0, 2, 0, 0, 0, 0, 0);
    fe(OP_LD, 0); de(OP_LD, 0); ex(OP_LD, 0, 2, 1, 0, 0, 0);
    add(1, 1, OP_LD, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, OP_LD, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    wb(OP_LD, 1, 0);
    add(1, 0, OP_R, 0, 0, 0, 2, 0, 0, 0, 0, 1);
    add(1, 1, OP_R, 0, 0, 0, 2, 0, 0, 0, 0, 1);
    add(1, 0, OP_R, 0, 6'b100100, 0, 2, 0, 0, 0, 0, 1);
    add(1, 0, OP_R, 1, 0, 0, 1, 0, 0, 0, 0, 1);
    add(1, 0, OP_R, 2, 0, 2, 0, 2, 0, 0, 0, 1);
    add(1, 0, OP_R, 4, 6'b000001, 0, 0, 0, 0, 1, 0, 1);
    add(1, 0, OP_ST, 0, 0, 0, 2, 0, 0, 0, 0, 2);
    add(1, 1, OP_ST, 0, 0, 0, 2, 0, 0, 0, 0, 2);
    fe(OP_ST, 2); de(OP_ST, 2); ex(OP_ST, 0, 2, 1, 0, 0, 2);
    add(1, 1, OP_ST, 3, 6'b000010, 0, 0, 0, 0, 1, 0, 2);
    add(1, 1, OP_BR, 0, 0, 0, 2, 0, 0, 0, 0, 3);
    fe(OP_BR, 3); de(OP_BR, 3); ex(OP_BR, 6'b011000, 2, 0, 1, 1, 3);
    add(1, 0, OP_R, 0, 0, 0, 2, 0, 0, 0, 0, 4);
    run_vecs(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
